// File: rtl/apb3_timer.sv
// apb3_timer -- APB3 completer with a prescaled 32-bit timer/compare unit.
//
// Register map (byte offset = paddr[7:0]):
//   0x00 CTRL    RW  [0] EN, [1] ONESHOT, [2] IRQ_EN
//   0x04 PRESC   RW  [15:0] timer ticks once every PRESC+1 enabled clocks
//   0x08 COMPARE RW  32-bit compare value
//   0x0C COUNT   RW  write loads the counter and restarts the prescaler
//   0x10 STATUS  W1C [0] MATCH (sticky)
//   0x14 ID      RO  ID_VALUE
// Unmapped, misaligned or ID-write accesses complete with pslverr=1, prdata=0.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   psel, penable, pwrite APB3 control
//   paddr, pwdata         APB3 address / write data (only paddr[7:0] decoded)
//   prdata, pready        read data (0 unless completing a read), completion
//   pslverr               error response, qualified by pready
//   o_irq                 registered level interrupt = MATCH & IRQ_EN
module apb3_timer #(
  parameter int          APB3_ADDR_WIDTH = 32,
  parameter int          APB3_DATA_WIDTH = 32,
  parameter int          WAIT_STATES     = 0,
  parameter logic [31:0] ID_VALUE        = 32'h7131_0001
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [APB3_ADDR_WIDTH-1:0] paddr,
  input  logic [APB3_DATA_WIDTH-1:0] pwdata,
  output logic [APB3_DATA_WIDTH-1:0] prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic                       o_irq
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_PRESC   = 8'h04;
  localparam logic [7:0] OFF_COMPARE = 8'h08;
  localparam logic [7:0] OFF_COUNT   = 8'h0C;
  localparam logic [7:0] OFF_STATUS  = 8'h10;
  localparam logic [7:0] OFF_ID      = 8'h14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        xfer_done;

  logic        en_q, en_d;
  logic        oneshot_q, oneshot_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] cnt_q, cnt_d;
  logic        match_q, match_d;
  logic        irq_q, irq_d;

  logic [7:0]  off;
  logic        addr_hit;
  logic        acc_err;
  logic [31:0] rdata;
  logic        wr_en;
  logic        wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
  logic        tick, tick_act, match_evt;

  // Upper address bits are outside the decoded window.
  logic        unused_paddr;
  assign unused_paddr = ^paddr[APB3_ADDR_WIDTH-1:8];

  // APB transfer FSM
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    xfer_done = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (psel && !penable) begin
          state_d = ST_ACCESS;
          wait_d  = WAIT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          // Select dropped mid-transfer: abandon it without committing.
          state_d = ST_IDLE;
        end else if (penable) begin
          if (wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
          end else begin
            xfer_done = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Address decode and read mux
  assign off = paddr[7:0];

  always_comb begin
    addr_hit = 1'b1;
    rdata    = 32'd0;
    case (off)
      OFF_CTRL:    rdata = {29'd0, irq_en_q, oneshot_q, en_q};
      OFF_PRESC:   rdata = {16'd0, presc_q};
      OFF_COMPARE: rdata = cmp_q;
      OFF_COUNT:   rdata = cnt_q;
      OFF_STATUS:  rdata = {31'd0, match_q};
      OFF_ID:      rdata = ID_VALUE;
      default:     addr_hit = 1'b0;
    endcase
  end

  // Misaligned offsets never match a map entry, so addr_hit covers them.
  assign acc_err = !addr_hit || (pwrite && (off == OFF_ID));

  assign pready  = xfer_done;
  assign pslverr = xfer_done && acc_err;
  assign prdata  = (xfer_done && !pwrite && !acc_err) ? rdata : '0;

  assign wr_en     = xfer_done && pwrite && !acc_err;
  assign wr_ctrl   = wr_en && (off == OFF_CTRL);
  assign wr_presc  = wr_en && (off == OFF_PRESC);
  assign wr_cmp    = wr_en && (off == OFF_COMPARE);
  assign wr_count  = wr_en && (off == OFF_COUNT);
  assign wr_status = wr_en && (off == OFF_STATUS);

  // Timer: a COUNT write overrides any tick landing on the same edge.
  assign tick      = en_q && (pcnt_q == presc_q);
  assign tick_act  = tick && !wr_count;
  assign match_evt = tick_act && (cnt_q == cmp_q);

  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    presc_d   = presc_q;
    cmp_d     = cmp_q;
    pcnt_d    = pcnt_q;
    cnt_d     = cnt_q;
    match_d   = match_q;

    if (wr_ctrl) begin
      en_d      = pwdata[0];
      oneshot_d = pwdata[1];
      irq_en_d  = pwdata[2];
    end else if (match_evt && oneshot_q) begin
      en_d = 1'b0;
    end

    if (wr_presc) presc_d = pwdata[15:0];
    if (wr_cmp)   cmp_d   = pwdata[31:0];

    // A PRESC lowered below the running prescaler lets it wrap through 0xFFFF.
    if (wr_count) begin
      cnt_d  = pwdata[31:0];
      pcnt_d = 16'd0;
    end else if (en_q) begin
      if (tick) begin
        pcnt_d = 16'd0;
        cnt_d  = match_evt ? 32'd0 : cnt_q + 32'd1;
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end

    // Hardware set beats a software clear in the same cycle.
    if (match_evt) begin
      match_d = 1'b1;
    end else if (wr_status && pwdata[0]) begin
      match_d = 1'b0;
    end
  end

  assign irq_d = match_d && irq_en_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      irq_en_q  <= 1'b0;
      presc_q   <= 16'd0;
      pcnt_q    <= 16'd0;
      cmp_q     <= 32'd0;
      cnt_q     <= 32'd0;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      irq_en_q  <= irq_en_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      cmp_q     <= cmp_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      irq_q     <= irq_d;
    end
  end

  assign o_irq = irq_q;

endmodule

// File: tb/tb_apb3_timer.sv
module tb_apb3_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        o_irq;

  always #5 clk = ~clk;

  apb3_timer #(
    .APB3_ADDR_WIDTH(32),
    .APB3_DATA_WIDTH(32),
    .WAIT_STATES(3),
    .ID_VALUE(32'h7131_0001)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .o_irq   (o_irq)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every completed transfer is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && pready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready: got pready 1 with no transfer pending, expected 0");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, "_prdata"}, prdata, e.data);
        chk({nm, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one APB transfer starting just after a rising edge; returns just
  // after the completion edge with the number of wait cycles observed.
  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input string nm, output int waits);
    bit done;
    exp_q.push_back({exp_rd, exp_err});
    name_q.push_back(nm);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {24'd0, a}; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      if (pready === 1'b1) done = 1'b1;
      else waits++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pready in 32 cycles, expected completion", nm);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string nm);
    int w;
    apb(1'b1, a, d, 32'd0, 1'b0, nm, w);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    int w;
    apb(1'b0, a, 32'd0, exp, 1'b0, nm, w);
  endtask

  initial begin
    int  w;
    bit  seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_irq", {31'd0, o_irq}, 32'd0);
    rst_n = 1'b1;
    wait_edges(1);

    rd(8'h00, 32'd0, "rd_ctrl0");
    rd(8'h04, 32'd0, "rd_presc0");
    rd(8'h08, 32'd0, "rd_compare0");
    rd(8'h0C, 32'd0, "rd_count0");
    rd(8'h10, 32'd0, "rd_status0");
    rd(8'h14, 32'h7131_0001, "rd_id");
    chk("irq_after_reset", {31'd0, o_irq}, 32'd0);

    // Wait states and aborted transfer
    apb(1'b1, 8'h08, 32'hDEAD_BEEF, 32'd0, 1'b0, "wr_compare", w);
    chk("wait_states_wr", w, 32'd3);
    apb(1'b0, 8'h08, 32'd0, 32'hDEAD_BEEF, 1'b0, "rd_compare", w);
    chk("wait_states_rd", w, 32'd3);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h1234_5678;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    wait_edges(1);
    rd(8'h08, 32'hDEAD_BEEF, "rd_compare_after_abort");

    // Error responses
    apb(1'b0, 8'h18, 32'd0, 32'd0, 1'b1, "rd_unmapped", w);
    apb(1'b0, 8'h02, 32'd0, 32'd0, 1'b1, "rd_misaligned", w);
    apb(1'b1, 8'h14, 32'hFFFF_FFFF, 32'd0, 1'b1, "wr_id", w);
    rd(8'h14, 32'h7131_0001, "rd_id_after_err");

    // Periodic match: PRESC=4, COMPARE=3 -> match every 20 cycles
    wr(8'h04, 32'd4, "wr_presc4");
    wr(8'h08, 32'd3, "wr_compare3");
    wr(8'h00, 32'h5, "wr_ctrl_en_irq");
    wait_edges(19);
    chk("irq_before_match1", {31'd0, o_irq}, 32'd0);
    wait_edges(1);
    chk("irq_at_match1", {31'd0, o_irq}, 32'd1);
    wr(8'h10, 32'd1, "w1c_status1");
    chk("irq_after_w1c1", {31'd0, o_irq}, 32'd0);
    wait_edges(14);
    chk("irq_before_match2", {31'd0, o_irq}, 32'd0);
    wait_edges(1);
    chk("irq_at_match2", {31'd0, o_irq}, 32'd1);
    wr(8'h00, 32'd0, "wr_ctrl_stop");
    rd(8'h0C, 32'd1, "rd_count_after_stop");
    rd(8'h10, 32'd1, "rd_status_periodic");

    // One-shot: PRESC=0, COMPARE=2
    wr(8'h04, 32'd0, "wr_presc0");
    wr(8'h08, 32'd2, "wr_compare2");
    wr(8'h0C, 32'd0, "wr_count0");
    wr(8'h10, 32'd1, "w1c_status2");
    chk("irq_cleared_before_oneshot", {31'd0, o_irq}, 32'd0);
    wr(8'h00, 32'h7, "wr_ctrl_oneshot");
    rd(8'h00, 32'h6, "rd_ctrl_en_cleared");
    rd(8'h0C, 32'd0, "rd_count_oneshot");
    chk("irq_oneshot", {31'd0, o_irq}, 32'd1);
    rd(8'h10, 32'd1, "rd_status_oneshot");
    wr(8'h10, 32'd1, "w1c_status3");
    chk("irq_drop_after_w1c", {31'd0, o_irq}, 32'd0);

    // Wrap: COUNT=FFFF_FFFF, COMPARE=5 -> wraps to 0 without MATCH
    wr(8'h00, 32'd0, "wr_ctrl_off");
    wr(8'h0C, 32'hFFFF_FFFF, "wr_count_max");
    wr(8'h08, 32'd5, "wr_compare5");
    wr(8'h00, 32'h1, "wr_ctrl_en");
    wr(8'h00, 32'h0, "wr_ctrl_stop2");
    rd(8'h0C, 32'd4, "rd_count_wrapped");
    rd(8'h10, 32'd0, "rd_status_no_match");

    // W1C landing on the same edge as a match: set wins
    wr(8'h0C, 32'd0, "wr_count0b");
    wr(8'h08, 32'd4, "wr_compare4");
    wr(8'h00, 32'h3, "wr_ctrl_en_oneshot");
    wr(8'h10, 32'd1, "w1c_collide");
    rd(8'h10, 32'd1, "rd_status_set_wins");

    // Reset asserted while a read is completing
    wr(8'h00, 32'h4, "wr_ctrl_irqen");
    chk("irq_before_reset", {31'd0, o_irq}, 32'd1);
    exp_q.push_back({32'h7131_0001, 1'b0});
    name_q.push_back("rd_id_reset");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h14;
    @(posedge clk); #1;
    penable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk);
      if (pready === 1'b1) seen = 1'b1;
    end
    chk("reset_access_reached", {31'd0, seen}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pready", {31'd0, pready}, 32'd0);
    chk("midrst_prdata", prdata, 32'd0);
    chk("midrst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("midrst_irq", {31'd0, o_irq}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    wait_edges(1);
    rst_n = 1'b1;
    wait_edges(1);
    rd(8'h00, 32'd0, "rd_ctrl_post_rst");
    rd(8'h10, 32'd0, "rd_status_post_rst");
    rd(8'h08, 32'd0, "rd_compare_post_rst");

    wait_edges(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb3_timer.md
Name: apb3_timer

Overview:
- APB3 completer holding a memory-mapped, prescaled 32-bit timer/compare unit with a level interrupt.
- Sits on the APB3 side of the AXI4-to-APB3 bridge at APB slave base 32'h0000_0400, in the student-module slot of the SoC top.
- Gives the SCR1 core a software-visible time base and a match interrupt.

Parameters:
- APB3_ADDR_WIDTH, 32, width of paddr.
- APB3_DATA_WIDTH, 32, width of pwdata/prdata; only 32 is supported.
- WAIT_STATES, 0, number of access-phase cycles with pready low before completion (0..15).
- ID_VALUE, 32'h7131_0001, constant returned by the ID register.

Ports:
- i_clk  in  1  system clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- psel  in  1  APB3 select.
- penable  in  1  APB3 enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  APB3_ADDR_WIDTH  byte address; only paddr[7:0] is decoded.
- pwdata  in  APB3_DATA_WIDTH  write data.
- prdata  out  APB3_DATA_WIDTH  read data; valid only when pready=1 in the access phase, 0 otherwise.
- pready  out  1  transfer completion.
- pslverr  out  1  error response; valid only with pready=1.
- o_irq  out  1  level interrupt = STATUS.MATCH & CTRL.IRQ_EN; driven from flops only.

Behaviour:
- Reset, asynchronous on i_rst_n low: all registers, counters and the FSM clear. Outputs at reset: prdata=0, pready=0, pslverr=0, o_irq=0. A transfer in flight during reset is dropped without commit.

Register map (offset = paddr[7:0]):
- 0x00 CTRL RW: [0] EN, [1] ONESHOT, [2] IRQ_EN; other bits read 0.
- 0x04 PRESC RW: [15:0]; the timer ticks once every PRESC+1 enabled clocks.
- 0x08 COMPARE RW: 32 bits.
- 0x0C COUNT RW: a write loads the counter and clears the prescaler.
- 0x10 STATUS: [0] MATCH, sticky; writing 1 clears it (W1C), writing 0 has no effect.
- 0x14 ID RO: returns ID_VALUE.
- Error cases: an unmapped offset, paddr[1:0]!=0, or a write to ID completes with pslverr=1, prdata=0 and no state change.

APB FSM:
- States are IDLE, ACCESS and DONE.
- IDLE -> ACCESS on psel & !penable (setup phase); the wait counter is loaded with WAIT_STATES.
- In ACCESS with psel & penable, the counter decrements while nonzero, with pready=0.
- When the counter is 0, the transfer completes: pready=1 for exactly one cycle and the FSM goes to DONE.
- A write commits on that completion edge. Read data is driven combinationally from the registers in the completion cycle.
- DONE -> IDLE on the next cycle; back-to-back setup is accepted from DONE or IDLE.
- WAIT_STATES=0 gives zero-wait completion in the first access cycle.
- If psel drops while in ACCESS (protocol violation), return to IDLE with no commit and pready kept low.

Timer:
- When EN=1, the prescaler counts 0..PRESC; a tick occurs on the cycle the prescaler equals PRESC, and the prescaler then returns to 0.
- On a tick:
  - If COUNT==COMPARE: set MATCH, set COUNT to 0, and clear EN if ONESHOT=1.
  - Otherwise COUNT increments by 1, wrapping from 0xFFFF_FFFF to 0 with no flag.
- EN=0 freezes both the prescaler and COUNT.
- PRESC=0 gives a tick every enabled cycle.

Simultaneous events:
- A MATCH set and a STATUS W1C in the same cycle: set wins, MATCH stays 1.
- An APB COUNT write and a tick in the same cycle: the write wins and the prescaler restarts.
- An APB CTRL write and a one-shot EN clear in the same cycle: the APB write wins.
- A write to PRESC does not reset the running prescaler. If the new PRESC is below the current prescaler value, the prescaler runs on to 0xFFFF, wraps to 0, and ticks when it next equals the new PRESC.

Test Plan:
- Reset then read 0x00, 0x04, 0x08, 0x0C, 0x10 -> all 0, pslverr=0, o_irq=0. Read 0x14 -> 32'h7131_0001.
- Build with WAIT_STATES=3. A write then read of COMPARE=32'hDEAD_BEEF -> pready low for 3 access cycles then high for 1, and the readback equals DEAD_BEEF. Dropping psel mid-wait leaves COMPARE unchanged.
- PRESC=4, COMPARE=3, CTRL=3'b101 -> MATCH and o_irq rise 20 cycles after enable, COUNT returns to 0, and the cycle repeats every 20 cycles.
- ONESHOT: CTRL=3'b111, PRESC=0, COMPARE=2 -> MATCH set after 3 ticks, EN reads 0, and COUNT stays 0. A W1C of STATUS=1 drops o_irq on the next cycle.
- Read 0x18, read 0x02, and write 0x14 -> each completes with pslverr=1 and prdata=0, and the ID read afterwards is unchanged.
- Edge cases:
  - COUNT=32'hFFFF_FFFF, COMPARE=5, PRESC=0, EN=1 -> COUNT wraps to 0 with no MATCH.
  - W1C issued on the same cycle as a match -> MATCH remains 1.
  - Asserting reset mid-access -> all outputs 0 immediately.
